// File: rtl/pwm_deadtime.sv
// Complementary high/low gate driver with programmable dead time and a
// sticky fault latch. One raw PWM channel is registered once, then steered
// to o_pwm_h / o_pwm_l so the two switches are never on together and every
// hand-over between them passes through a dead interval of dt_eff cycles.
//
// Handshake: none. Every input is sampled as a level on each rising edge
// of i_clk; i_fault_clr is a single-cycle request acted on in the cycle it
// is seen. There is no valid/ready pairing on this block.
//
// o_dbg_state exposes the FSM encoding for checkers:
//   0 OFF, 1 LOW_ON, 2 DEAD_TO_HIGH, 3 HIGH_ON, 4 DEAD_TO_LOW
module pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pwm,
  input  logic            i_en,
  input  logic [DT_W-1:0] i_dt_rise,
  input  logic [DT_W-1:0] i_dt_fall,
  input  logic            i_fault,
  input  logic            i_fault_clr,
  output logic            o_pwm_h,
  output logic            o_pwm_l,
  output logic            o_dead,
  output logic            o_fault,
  output logic [2:0]      o_dbg_state
);

  typedef enum logic [2:0] {
    S_OFF          = 3'd0,
    S_LOW_ON       = 3'd1,
    S_DEAD_TO_HIGH = 3'd2,
    S_HIGH_ON      = 3'd3,
    S_DEAD_TO_LOW  = 3'd4
  } state_t;

  localparam logic [DT_W-1:0] DT_ZERO = '0;
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  state_t          r_state;
  logic            r_pwm_q;
  logic            r_primed;
  logic [DT_W-1:0] r_cnt;
  logic            r_h;
  logic            r_l;
  logic            r_dead;
  logic            r_fault;

  logic [DT_W-1:0] w_dt_rise_eff;
  logic [DT_W-1:0] w_dt_fall_eff;

  // A programmed dead time of zero is treated as one cycle so the two
  // switches can never be driven in adjacent cycles without a gap.
  always_comb begin
    w_dt_rise_eff = (i_dt_rise == DT_ZERO) ? DT_ONE : i_dt_rise;
    w_dt_fall_eff = (i_dt_fall == DT_ZERO) ? DT_ONE : i_dt_fall;
  end

  // Input register, fault latch and gate-drive FSM; outputs are flops that
  // change on the same edge as the state. Priority on each edge is
  // reset, fault, disable, abort, dead-count expiry, PWM transition.
  // r_primed holds the FSM in OFF for the first edge after reset so that
  // r_pwm_q carries a real sample before any decision is made.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_OFF;
      r_pwm_q  <= 1'b0;
      r_primed <= 1'b0;
      r_cnt    <= DT_ZERO;
      r_h      <= 1'b0;
      r_l      <= 1'b0;
      r_dead   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_pwm_q  <= i_pwm;
      r_primed <= 1'b1;
      if (i_fault) begin
        // Trip: latch the fault and drop both switches on this edge.
        r_fault <= 1'b1;
        r_state <= S_OFF;
        r_cnt   <= DT_ZERO;
        r_h     <= 1'b0;
        r_l     <= 1'b0;
        r_dead  <= 1'b0;
      end else if (r_fault) begin
        // Latched fault: stay OFF; a clear only releases the latch, the
        // FSM leaves OFF on the following edge.
        if (i_fault_clr) begin
          r_fault <= 1'b0;
        end
        r_state <= S_OFF;
        r_cnt   <= DT_ZERO;
        r_h     <= 1'b0;
        r_l     <= 1'b0;
        r_dead  <= 1'b0;
      end else if (!r_primed || !i_en) begin
        r_state <= S_OFF;
        r_cnt   <= DT_ZERO;
        r_h     <= 1'b0;
        r_l     <= 1'b0;
        r_dead  <= 1'b0;
      end else begin
        case (r_state)
          S_OFF: begin
            if (r_pwm_q) begin
              r_state <= S_DEAD_TO_HIGH;
              r_cnt   <= w_dt_rise_eff;
              r_h     <= 1'b0;
              r_l     <= 1'b0;
              r_dead  <= 1'b1;
            end else begin
              r_state <= S_LOW_ON;
              r_h     <= 1'b0;
              r_l     <= 1'b1;
              r_dead  <= 1'b0;
            end
          end
          S_LOW_ON: begin
            if (r_pwm_q) begin
              r_state <= S_DEAD_TO_HIGH;
              r_cnt   <= w_dt_rise_eff;
              r_l     <= 1'b0;
              r_dead  <= 1'b1;
            end
          end
          S_DEAD_TO_HIGH: begin
            if (!r_pwm_q) begin
              // Request withdrawn: low side may simply resume.
              r_state <= S_LOW_ON;
              r_cnt   <= DT_ZERO;
              r_l     <= 1'b1;
              r_dead  <= 1'b0;
            end else if (r_cnt == DT_ONE) begin
              r_state <= S_HIGH_ON;
              r_cnt   <= DT_ZERO;
              r_h     <= 1'b1;
              r_dead  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - DT_ONE;
            end
          end
          S_HIGH_ON: begin
            if (!r_pwm_q) begin
              r_state <= S_DEAD_TO_LOW;
              r_cnt   <= w_dt_fall_eff;
              r_h     <= 1'b0;
              r_dead  <= 1'b1;
            end
          end
          S_DEAD_TO_LOW: begin
            if (r_pwm_q) begin
              // Request withdrawn: high side may simply resume.
              r_state <= S_HIGH_ON;
              r_cnt   <= DT_ZERO;
              r_h     <= 1'b1;
              r_dead  <= 1'b0;
            end else if (r_cnt == DT_ONE) begin
              r_state <= S_LOW_ON;
              r_cnt   <= DT_ZERO;
              r_l     <= 1'b1;
              r_dead  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - DT_ONE;
            end
          end
          default: begin
            r_state <= S_OFF;
            r_cnt   <= DT_ZERO;
            r_h     <= 1'b0;
            r_l     <= 1'b0;
            r_dead  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_pwm_h     = r_h;
  assign o_pwm_l     = r_l;
  assign o_dead      = r_dead;
  assign o_fault     = r_fault;
  assign o_dbg_state = r_state;

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 Parameter DT_W, default 8: width of the dead-time count inputs and internal counter.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset; synchronous, active-high.
REQ-004 i_pwm  input  1  raw PWM from one pwm_timer channel output (o_pwm[n]), synchronous to i_clk.
REQ-005 i_en  input  1  block enable; 0 forces both outputs low.
REQ-006 i_dt_rise  input  DT_W  dead cycles between o_pwm_l falling and o_pwm_h rising.
REQ-007 i_dt_fall  input  DT_W  dead cycles between o_pwm_h falling and o_pwm_l rising.
REQ-008 i_fault  input  1  external fault (overcurrent/trip), level-sensitive.
REQ-009 i_fault_clr  input  1  single-cycle request to clear latched fault.
REQ-010 o_pwm_h  output  1  high-side gate drive, registered.
REQ-011 o_pwm_l  output  1  low-side gate drive, registered.
REQ-012 o_dead  output  1  high while a dead interval is in progress, registered.
REQ-013 o_fault  output  1  sticky fault flag, registered.

Function
REQ-014 i_pwm shall be registered once (pwm_q); all decisions use pwm_q, never raw i_pwm.
REQ-015 FSM states: OFF, LOW_ON, DEAD_TO_HIGH, HIGH_ON, DEAD_TO_LOW; outputs are flops updated on the same edge as the state: OFF/DEAD_*: h=0,l=0; LOW_ON: l=1; HIGH_ON: h=1.
REQ-016 o_pwm_h and o_pwm_l shall never both be 1 in any cycle, including reset, fault and abort paths.
REQ-017 Effective dead time dt_eff = max(i_dt_x, 1); a value of 0 shall behave exactly as 1.
REQ-018 On entry to a DEAD_* state the counter loads dt_eff of the relevant input; later changes to i_dt_* do not affect an interval in progress.
REQ-019 In DEAD_* the counter decrements each cycle; at an edge where counter==1 the FSM enters HIGH_ON (from DEAD_TO_HIGH) or LOW_ON (from DEAD_TO_LOW); both outputs low for exactly dt_eff cycles.
REQ-020 LOW_ON -> DEAD_TO_HIGH when pwm_q==1; HIGH_ON -> DEAD_TO_LOW when pwm_q==0.
REQ-021 Abort: in DEAD_TO_HIGH with pwm_q==0 go to LOW_ON next edge; in DEAD_TO_LOW with pwm_q==1 go to HIGH_ON next edge (the turning-off switch may resume; no dead interval needed).
REQ-022 Latency: i_pwm edge sampled at clock edge E0 -> turning-off output drops at E0+1 -> turning-on output rises at E0+1+dt_eff.
REQ-023 OFF exit (i_en==1, o_fault==0): pwm_q==0 -> LOW_ON; pwm_q==1 -> DEAD_TO_HIGH with dt_eff from i_dt_rise.
REQ-024 i_en==0 in any state -> OFF at next edge; counter cleared.
REQ-025 i_fault==1 sampled at an edge -> o_fault=1 and state OFF at that edge; o_fault stays 1 while in OFF regardless of i_en.
REQ-026 o_fault clears only on an edge with i_fault_clr==1 and i_fault==0; simultaneous i_fault and i_fault_clr -> fault wins, o_fault stays 1.
REQ-027 After clear, FSM stays OFF for that edge and exits per REQ-023 on the next edge.
REQ-028 Priority per edge: i_rst > i_fault > i_en==0 > abort > dead-count expiry > pwm_q transition.
REQ-029 o_dead = 1 exactly in DEAD_TO_HIGH and DEAD_TO_LOW.

Reset
REQ-030 On i_rst==1 at an edge: state OFF, pwm_q=0, counter=0, o_pwm_h=0, o_pwm_l=0, o_dead=0, o_fault=0.
REQ-031 Reset asserted mid-dead-interval or mid-fault shall produce the REQ-030 values on the same edge; no output pulse on release.
REQ-032 After release, first state change no earlier than the second edge (pwm_q pipeline refill).

Verification
REQ-033 dt_rise=3, en=1, i_pwm 0->1 sampled at edge 10 -> o_pwm_l=0 from edge 11, o_pwm_h=1 from edge 14, o_dead=1 for edges 11-13.
REQ-034 dt_fall=0, i_pwm 1->0 sampled at edge 20 -> o_pwm_h=0 at edge 21, o_pwm_l=1 at edge 22 (dt_eff=1).
REQ-035 dt_rise=5, i_pwm high for 2 cycles only -> DEAD_TO_HIGH aborted, o_pwm_h never asserts, o_pwm_l returns 1 within 1 cycle of pwm_q falling.
REQ-036 i_fault pulse during HIGH_ON -> both outputs 0 next edge, o_fault=1; fault_clr with i_fault=1 ignored; clr with i_fault=0 -> o_fault=0, LOW_ON/DEAD_TO_HIGH one edge later.
REQ-037 Random i_pwm, random i_dt_* (including 0 and 2^DT_W-1), random en/fault/reset -> assertion: never o_pwm_h&&o_pwm_l; every h/l hand-over has >= dt_eff low cycles.
